// File: rtl/uart_tx_if.sv
// Parallel request / serial line bundle between the upstream sync stage and uart_tx.
interface uart_tx_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  BUSY;

  modport master (output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, input TX_OUT, BUSY);
  modport slave  (input P_DATA, DATA_VALID, PAR_EN, PAR_TYP, output TX_OUT, BUSY);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH bits LSB-first, optional parity, one stop; CLK is the bit clock.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_if.slave bus
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                r_state, w_state;
  logic                  r_tx, w_tx;
  logic                  r_busy;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift;
  logic                  w_accept;

`ifdef UART_TX_PARITY_EN
  logic r_par, w_par, r_par_en, w_par_en;
`else
  logic w_unused_par;
  assign w_unused_par = bus.PAR_EN ^ bus.PAR_TYP;
`endif

  // A new frame may start while the stop bit is on the line, giving zero-gap back-to-back frames.
  assign w_accept = bus.DATA_VALID && (r_state == S_IDLE || r_state == S_STOP);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_shift = r_shift;
    w_tx    = 1'b1;
`ifdef UART_TX_PARITY_EN
    w_par    = r_par;
    w_par_en = r_par_en;
`endif
    case (r_state)
      S_START: w_state = S_DATA;
      S_DATA: begin
        if (r_cnt == CW'(DATA_WIDTH - 1)) begin
          w_cnt = '0;
`ifdef UART_TX_PARITY_EN
          w_state = r_par_en ? S_PARITY : S_STOP;
`else
          w_state = S_STOP;
`endif
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_state = S_STOP;
`endif
      S_STOP:  w_state = S_IDLE;
      default: w_state = r_state;
    endcase

    if (w_accept) begin
      w_state = S_START;
      w_shift = bus.P_DATA;
`ifdef UART_TX_PARITY_EN
      w_par    = (^bus.P_DATA) ^ bus.PAR_TYP;
      w_par_en = bus.PAR_EN;
`endif
    end

    // Line value is that of the state being entered, so outputs come straight from flops.
    case (w_state)
      S_START: w_tx = 1'b0;
      S_DATA: begin
        w_tx    = r_shift[0];
        w_shift = r_shift >> 1;
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx = r_par;
`endif
      default: w_tx = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
`ifdef UART_TX_PARITY_EN
      r_par    <= 1'b0;
      r_par_en <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_tx    <= w_tx;
      r_busy  <= (w_state != S_IDLE);
      r_cnt   <= w_cnt;
      r_shift <= w_shift;
`ifdef UART_TX_PARITY_EN
      r_par    <= w_par;
      r_par_en <= w_par_en;
`endif
    end
  end

  assign bus.TX_OUT = r_tx;
  assign bus.BUSY   = r_busy;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: expected line waveforms are built frame-by-frame from the framing rules.
module tb_uart_tx;
  localparam int DW = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  uart_tx_if #(.DATA_WIDTH(DW)) bus ();
  uart_tx #(.DATA_WIDTH(DW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;
  logic exp_tx[$], exp_busy[$], obs_tx[$], obs_busy[$];

  task automatic clear_q();
    exp_tx.delete(); exp_busy.delete(); obs_tx.delete(); obs_busy.delete();
  endtask

  // Reference frame: start 0, data LSB-first, parity if compiled in and requested, stop 1.
  task automatic model_frame(input logic [DW-1:0] d, input bit pen, input bit ptyp);
    int ones = 0;
    bit pb;
    exp_tx.push_back(1'b0); exp_busy.push_back(1'b1);
    for (int i = 0; i < DW; i++) begin
      exp_tx.push_back(d[i]); exp_busy.push_back(1'b1);
      ones += int'(d[i]);
    end
    pb = bit'(ones % 2) ^ ptyp;
`ifdef UART_TX_PARITY_EN
    if (pen) begin
      exp_tx.push_back(pb); exp_busy.push_back(1'b1);
    end
`else
    if (pen && pb) exp_tx.push_back(1'b1);
    if (pen && pb) void'(exp_tx.pop_back());
`endif
    exp_tx.push_back(1'b1); exp_busy.push_back(1'b1);
  endtask

  task automatic model_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(1'b1); exp_busy.push_back(1'b0);
    end
  endtask

  // Samples the line each cycle, #1 after the edge; optionally scrambles non-valid inputs.
  task automatic capture(input int n, input bit scr);
    for (int i = 0; i < n; i++) begin
      obs_tx.push_back(bus.TX_OUT); obs_busy.push_back(bus.BUSY);
      if (scr) begin
        bus.P_DATA  = DW'($urandom);
        bus.PAR_EN  = 1'($urandom_range(0, 1));
        bus.PAR_TYP = 1'($urandom_range(0, 1));
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic kick(input logic [DW-1:0] d, input bit pen, input bit ptyp);
    bus.P_DATA = d; bus.PAR_EN = pen; bus.PAR_TYP = ptyp; bus.DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    bus.DATA_VALID = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK); #1;
    checks++;
    if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0)
      $display("FAIL reset_hold tx=%b busy=%b expected tx=1 busy=0", bus.TX_OUT, bus.BUSY);
    else passes++;
    RST = 1'b1;
    clear_q();
    kick(8'hC3, 1'b0, 1'b0);
    capture(5, 1'b0);
    RST = 1'b0; #1;
    checks++;
    if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0)
      $display("FAIL reset_async tx=%b busy=%b expected tx=1 busy=0", bus.TX_OUT, bus.BUSY);
    else passes++;
    @(posedge CLK); #1;
    RST = 1'b1;
    clear_q();
    model_idle(6);
    capture(6, 1'b0);
    for (int i = 0; i < exp_tx.size(); i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i])
        $display("FAIL reset_idle cyc%0d tx=%b busy=%b expected tx=%b busy=%b",
                 i, obs_tx[i], obs_busy[i], exp_tx[i], exp_busy[i]);
      else passes++;
    end
  endtask

  task automatic test_no_parity();
    clear_q();
    model_frame(8'hA5, 1'b0, 1'b0);
    model_idle(2);
    kick(8'hA5, 1'b0, 1'b0);
    capture(exp_tx.size(), 1'b0);
    for (int i = 0; i < exp_tx.size(); i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i])
        $display("FAIL nopar cyc%0d tx=%b busy=%b expected tx=%b busy=%b",
                 i, obs_tx[i], obs_busy[i], exp_tx[i], exp_busy[i]);
      else passes++;
    end
  endtask

  task automatic test_parity();
    logic [DW-1:0] d[3] = '{8'hA5, 8'h07, 8'h07};
    bit            t[3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      clear_q();
      model_frame(d[k], 1'b1, t[k]);
      model_idle(1);
      kick(d[k], 1'b1, t[k]);
      capture(exp_tx.size(), 1'b0);
      for (int i = 0; i < exp_tx.size(); i++) begin
        checks++;
        if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i])
          $display("FAIL parity%0d cyc%0d tx=%b busy=%b expected tx=%b busy=%b",
                   k, i, obs_tx[i], obs_busy[i], exp_tx[i], exp_busy[i]);
        else passes++;
      end
    end
  endtask

  task automatic test_par_en_81();
    clear_q();
    model_frame(8'h81, 1'b1, 1'b0);
    model_idle(1);
    kick(8'h81, 1'b1, 1'b0);
    capture(exp_tx.size(), 1'b0);
    for (int i = 0; i < exp_tx.size(); i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i])
        $display("FAIL pen81 cyc%0d tx=%b busy=%b expected tx=%b busy=%b",
                 i, obs_tx[i], obs_busy[i], exp_tx[i], exp_busy[i]);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int n1;
    clear_q();
    model_frame(8'h55, 1'b0, 1'b0);
    n1 = exp_tx.size();
    model_frame(8'h0F, 1'b0, 1'b0);
    model_idle(2);
    bus.P_DATA = 8'h55; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < n1; i++) begin
      obs_tx.push_back(bus.TX_OUT); obs_busy.push_back(bus.BUSY);
      if (i == n1 - 1) bus.P_DATA = 8'h0F;
      @(posedge CLK); #1;
    end
    bus.DATA_VALID = 1'b0;
    capture(exp_tx.size() - n1, 1'b0);
    for (int i = 0; i < exp_tx.size(); i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i])
        $display("FAIL b2b cyc%0d tx=%b busy=%b expected tx=%b busy=%b",
                 i, obs_tx[i], obs_busy[i], exp_tx[i], exp_busy[i]);
      else passes++;
    end
  endtask

  task automatic test_ignored();
    clear_q();
    model_frame(8'h00, 1'b0, 1'b0);
    model_idle(4);
    kick(8'h00, 1'b0, 1'b0);
    capture(3, 1'b0);
    bus.P_DATA = 8'hFF; bus.DATA_VALID = 1'b1;
    capture(1, 1'b0);
    bus.DATA_VALID = 1'b0;
    capture(exp_tx.size() - 4, 1'b0);
    for (int i = 0; i < exp_tx.size(); i++) begin
      checks++;
      if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i])
        $display("FAIL ignored cyc%0d tx=%b busy=%b expected tx=%b busy=%b",
                 i, obs_tx[i], obs_busy[i], exp_tx[i], exp_busy[i]);
      else passes++;
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 24; f++) begin
      logic [DW-1:0] d;
      bit pen, ptyp;
      int gap;
      d    = DW'($urandom);
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      gap  = $urandom_range(1, 4);
      clear_q();
      model_frame(d, pen, ptyp);
      model_idle(gap);
      kick(d, pen, ptyp);
      capture(exp_tx.size(), 1'b1);
      for (int i = 0; i < exp_tx.size(); i++) begin
        checks++;
        if (obs_tx[i] !== exp_tx[i] || obs_busy[i] !== exp_busy[i])
          $display("FAIL rand f%0d d=%h pen=%b typ=%b cyc%0d tx=%b busy=%b expected tx=%b busy=%b",
                   f, d, pen, ptyp, i, obs_tx[i], obs_busy[i], exp_tx[i], exp_busy[i]);
        else passes++;
      end
    end
  endtask

  initial begin
    bus.P_DATA = '0; bus.DATA_VALID = 1'b0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    test_reset();
    test_no_parity();
    test_parity();
    test_par_en_81();
    test_back_to_back();
    test_ignored();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
